// File: rtl/calc_keyin.sv
// calc_keyin: operand-entry front end of the calculator datapath.
// Synchronizes and debounces a raw push-button level, turns each accepted
// press into a single-cycle key event, and runs the operand-entry state
// machine that feeds the downstream subtractor.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   KEY_PRESS  in   raw button level (asynchronous to CLK), active-high
//   KEY_IN     in   key code: 0-9 digit, A minus, B equals, C clear, D-F invalid
//   A_DATA     out  operand A (minuend)
//   B_DATA     out  operand B (subtrahend)
//   CALC_VALID out  high while the result is to be shown
//   DISP_SEL   out  display source: 00 A, 01 B, 10 result
//   ERR        out  one-cycle pulse after a rejected key
module calc_keyin #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_PRESS,
  input  logic [3:0] KEY_IN,
  output logic [3:0] A_DATA,
  output logic [3:0] B_DATA,
  output logic       CALC_VALID,
  output logic [1:0] DISP_SEL,
  output logic       ERR
);

  localparam logic [1:0] S_A   = 2'b00;
  localparam logic [1:0] S_B   = 2'b01;
  localparam logic [1:0] S_RES = 2'b10;

  localparam logic [3:0] K_MINUS  = 4'hA;
  localparam logic [3:0] K_EQUALS = 4'hB;
  localparam logic [3:0] K_CLEAR  = 4'hC;

  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES - 1);

  logic       r_sync1, r_sync2;
  logic       r_db, r_db_d;
  logic [7:0] r_cnt;
  logic [1:0] r_state;
  logic [3:0] r_a_data, r_b_data;
  logic       r_a_ent, r_b_ent;
  logic       r_calc_valid;
  logic       r_err;

  logic       w_kev;
  logic       w_digit;
  logic [1:0] w_state_nxt;
  logic [3:0] w_a_nxt, w_b_nxt;
  logic       w_a_ent_nxt, w_b_ent_nxt;
  logic       w_err_nxt;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= KEY_PRESS;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: the level must disagree for DEB_CYCLES consecutive cycles
  // before the debounced level follows it; any agreement restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_db_d <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == DEB_MAX) begin
        r_db  <= r_sync2;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Rising edge of the debounced level: one event per accepted press.
  assign w_kev   = r_db & ~r_db_d;
  assign w_digit = (KEY_IN <= 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a_data;
    w_b_nxt     = r_b_data;
    w_a_ent_nxt = r_a_ent;
    w_b_ent_nxt = r_b_ent;
    w_err_nxt   = 1'b0;
    if (w_kev) begin
      if (KEY_IN == K_CLEAR) begin
        w_state_nxt = S_A;
        w_a_nxt     = 4'd0;
        w_b_nxt     = 4'd0;
        w_a_ent_nxt = 1'b0;
        w_b_ent_nxt = 1'b0;
      end else if (KEY_IN > K_CLEAR) begin
        w_err_nxt = 1'b1;
      end else begin
        case (r_state)
          S_A: begin
            if (w_digit) begin
              w_a_nxt     = KEY_IN;
              w_a_ent_nxt = 1'b1;
            end else if (KEY_IN == K_MINUS) begin
              w_b_nxt     = 4'd0;
              w_b_ent_nxt = 1'b0;
              w_state_nxt = S_B;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          S_B: begin
            if (w_digit) begin
              w_b_nxt     = KEY_IN;
              w_b_ent_nxt = 1'b1;
            end else if (KEY_IN == K_EQUALS && r_b_ent) begin
              w_state_nxt = S_RES;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          S_RES: begin
            // A digit starts a fresh calculation with B cleared.
            if (w_digit) begin
              w_a_nxt     = KEY_IN;
              w_a_ent_nxt = 1'b1;
              w_b_nxt     = 4'd0;
              w_b_ent_nxt = 1'b0;
              w_state_nxt = S_A;
            end else if (KEY_IN == K_MINUS) begin
              w_err_nxt = 1'b1;
            end
          end
          default: w_state_nxt = S_A;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_A;
      r_a_data     <= 4'd0;
      r_b_data     <= 4'd0;
      r_a_ent      <= 1'b0;
      r_b_ent      <= 1'b0;
      r_calc_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_a_data     <= w_a_nxt;
      r_b_data     <= w_b_nxt;
      r_a_ent      <= w_a_ent_nxt;
      r_b_ent      <= w_b_ent_nxt;
      r_calc_valid <= (w_state_nxt == S_RES);
      r_err        <= w_err_nxt;
    end
  end

  assign A_DATA     = r_a_data;
  assign B_DATA     = r_b_data;
  assign CALC_VALID = r_calc_valid;
  assign DISP_SEL   = r_state;
  assign ERR        = r_err;

endmodule

// File: tb/tb_calc_keyin.sv
module tb_calc_keyin;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       KEY_PRESS = 1'b0;
  logic [3:0] KEY_IN = 4'd0;
  logic [3:0] A_DATA, B_DATA;
  logic       CALC_VALID;
  logic [1:0] DISP_SEL;
  logic       ERR;

  calc_keyin #(.DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY_PRESS(KEY_PRESS), .KEY_IN(KEY_IN),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .CALC_VALID(CALC_VALID),
    .DISP_SEL(DISP_SEL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int err_total = 0;

  always @(negedge CLK) if (ERR === 1'b1) err_total <= err_total + 1;

  // Reference model: calculator entry rules at the key level.
  int m_a, m_b, m_st;  // m_st: 0 entering A, 1 entering B, 2 showing result
  bit m_aent, m_bent;

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_st = 0; m_aent = 0; m_bent = 0;
  endfunction

  // Applies one accepted key; returns the number of ERR pulses expected.
  function automatic int model_key(input int k);
    bit digit = (k <= 9);
    if (k == 12) begin model_reset(); return 0; end
    if (k >= 13) return 1;
    if (m_st == 0) begin
      if (digit) begin m_a = k; m_aent = 1; end
      else if (k == 10) begin m_b = 0; m_bent = 0; m_st = 1; end
      else return 1;
    end else if (m_st == 1) begin
      if (digit) begin m_b = k; m_bent = 1; end
      else if (k == 11 && m_bent) m_st = 2;
      else return 1;
    end else begin
      if (digit) begin m_a = k; m_aent = 1; m_b = 0; m_bent = 0; m_st = 0; end
      else if (k == 10) return 1;
    end
    return 0;
  endfunction

  function automatic logic [10:0] exp_vec();
    return {4'(m_a), 4'(m_b), (m_st == 2), 2'(m_st)};
  endfunction

  // Holds the button for 'hold' cycles, then releases long enough to settle.
  task automatic press(input logic [3:0] k, input int hold, output int nerr);
    int e0;
    @(negedge CLK);
    e0 = err_total;
    KEY_IN = k;
    KEY_PRESS = 1'b1;
    repeat (hold) @(negedge CLK);
    KEY_PRESS = 1'b0;
    repeat (12) @(negedge CLK);
    nerr = err_total - e0;
  endtask

  task automatic test_reset();
    int n;
    #1;
    checks++;
    if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL, ERR} !== 12'd0) begin
      failures++;
      $display("FAIL reset_initial got=%h want=000", {A_DATA, B_DATA, CALC_VALID, DISP_SEL, ERR});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    press(4'd7, 10, n);
    void'(model_key(7));
    // Start a press and stop mid-debounce (counter at 2 after four edges).
    @(negedge CLK);
    KEY_IN = 4'd5;
    KEY_PRESS = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (dut.r_cnt !== 8'd2) begin
      failures++;
      $display("FAIL reset_middeb_cnt got=%0d want=2", dut.r_cnt);
    end
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL, ERR, dut.r_cnt} !== 20'd0) begin
      failures++;
      $display("FAIL reset_async got=%h want=00000", {A_DATA, B_DATA, CALC_VALID, DISP_SEL, ERR, dut.r_cnt});
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    KEY_PRESS = 1'b0;
    repeat (15) @(negedge CLK);
    checks++;
    if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== exp_vec()) begin
      failures++;
      $display("FAIL reset_no_event got=%h want=%h", {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, exp_vec());
    end
  endtask

  task automatic test_sequence();
    int n, rise, e0;
    logic [3:0] keys [3] = '{4'd7, 4'hA, 4'd3};
    e0 = err_total;
    foreach (keys[i]) begin
      press(keys[i], 10, n);
      void'(model_key(int'(keys[i])));
      checks++;
      if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== exp_vec()) begin
        failures++;
        $display("FAIL seq_step%0d got=%h want=%h", i, {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, exp_vec());
      end
    end
    @(negedge CLK);
    KEY_IN = 4'hB;
    KEY_PRESS = 1'b1;
    rise = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK);
      #1;
      if (CALC_VALID === 1'b1 && rise == 0) rise = e;
    end
    @(negedge CLK);
    KEY_PRESS = 1'b0;
    repeat (12) @(negedge CLK);
    void'(model_key(11));
    checks++;
    if (rise != 3 + DEB) begin
      failures++;
      $display("FAIL seq_calc_latency got=%0d want=%0d", rise, 3 + DEB);
    end
    checks++;
    if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== {4'd7, 4'd3, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL seq_result got=%h want=%h", {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, {4'd7, 4'd3, 1'b1, 2'b10});
    end
    checks++;
    if (err_total != e0) begin
      failures++;
      $display("FAIL seq_no_err got=%0d want=0", err_total - e0);
    end
  endtask

  task automatic test_glitch();
    int n;
    press(4'd5, 3, n);
    checks++;
    if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== exp_vec() || n != 0) begin
      failures++;
      $display("FAIL glitch got=%h err=%0d want=%h err=0", {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, n, exp_vec());
    end
    checks++;
    if (dut.r_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_cnt got=%0d want=0", dut.r_cnt);
    end
  endtask

  // Directed key tables: each entry is checked against the model for
  // outputs and ERR pulse count. Starts in S_RES with A=7, B=3.
  task automatic test_directed();
    int n, ex;
    logic [3:0] keys  [17] = '{4'd2, 4'hB, 4'hE, 4'hA, 4'hB, 4'hA, 4'hE, 4'd4, 4'hB,
                               4'hE, 4'hA, 4'hB, 4'd9, 4'hA, 4'd4, 4'hC, 4'hE};
    int         holds [17] = '{10, 10, 10, 10, 10, 10, 10, 10, 10,
                               10, 10, 10, 10, 10, 10, 40, 40};
    foreach (keys[i]) begin
      ex = model_key(int'(keys[i]));
      press(keys[i], holds[i], n);
      checks++;
      if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== exp_vec()) begin
        failures++;
        $display("FAIL dir_out%0d key=%h got=%h want=%h", i, keys[i], {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, exp_vec());
      end
      checks++;
      if (n != ex) begin
        failures++;
        $display("FAIL dir_err%0d key=%h got=%0d want=%0d", i, keys[i], n, ex);
      end
    end
  endtask

  task automatic test_random();
    int n, ex, k, h;
    for (int i = 0; i < 50; i++) begin
      k = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 11));
      h = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(DEB + 4, 20);
      ex = (h >= DEB) ? model_key(k) : 0;
      press(4'(k), h, n);
      checks++;
      if ({A_DATA, B_DATA, CALC_VALID, DISP_SEL} !== exp_vec() || n != ex) begin
        failures++;
        $display("FAIL rand%0d key=%h hold=%0d got=%h err=%0d want=%h err=%0d",
                 i, k, h, {A_DATA, B_DATA, CALC_VALID, DISP_SEL}, n, exp_vec(), ex);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_glitch();
    test_directed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
